postproc_lanes: RTL

POSTPROC_LANES -- requirements
Module: postproc_lanes

---
 rtl/postproc_lanes.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/postproc_lanes.sv
// postproc_lanes: per-lane post-processing of PE partial sums into OFM buffer writes.
//   Three-stage pipeline: bias/scale lookup, multiply, then round/activate/saturate.
//   Ports:
//     clk, rst                     - rising-edge clock, synchronous active-high reset
//     cfg_*  / cfg_load            - shift, leaky-ReLU enable, row width, channel-group plane size
//     tbl_we/addr/bias/scale       - per-channel bias/scale table write port (idle only)
//     pe_data_i/vld_i/row/col/chn  - one beat of LANES partial sums
//     ofm_we/addr/wdata            - OFM buffer write, 3 cycles after each beat
//     busy, tbl_err, sat_cnt       - pipeline occupancy, sticky table-write error, clip counter
module postproc_lanes #(
    parameter int LANES      = 4,
    parameter int PSUM_DW    = 32,
    parameter int BIAS_DW    = 16,
    parameter int SCALES_DW  = 16,
    parameter int W_OUT      = 8,
    parameter int W_SIZE     = 9,
    parameter int W_CHANNEL  = 10,
    parameter int OFM_BUF_AW = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [4:0]                  cfg_shift,
    input  logic                        cfg_act_en,
    input  logic [W_SIZE-1:0]           cfg_width,
    input  logic [OFM_BUF_AW-1:0]       cfg_plane,
    input  logic                        cfg_load,
    input  logic                        tbl_we,
    input  logic [W_CHANNEL-1:0]        tbl_addr,
    input  logic [BIAS_DW-1:0]          tbl_bias,
    input  logic [SCALES_DW-1:0]        tbl_scale,
    input  logic [LANES*PSUM_DW-1:0]    pe_data_i,
    input  logic                        pe_vld_i,
    input  logic [W_SIZE-1:0]           pe_row_i,
    input  logic [W_SIZE-1:0]           pe_col_i,
    input  logic [W_CHANNEL-1:0]        pe_chn_out_i,
    output logic                        ofm_we,
    output logic [OFM_BUF_AW-1:0]       ofm_addr,
    output logic [LANES*W_OUT-1:0]      ofm_wdata,
    output logic                        busy,
    output logic                        tbl_err,
    output logic [15:0]                 sat_cnt
);

    localparam int TW     = PSUM_DW + 1 + SCALES_DW + 1;  // full product width
    localparam int RW     = TW + 1;                       // headroom for the rounding add
    localparam int TBL_DW = BIAS_DW + SCALES_DW;
    localparam int DEPTH  = 1 << W_CHANNEL;

    localparam logic signed [RW-1:0] MAXV = {{(RW-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    // Configuration registers
    logic [4:0]            cfg_shift_q;
    logic                  cfg_act_q;
    logic [W_SIZE-1:0]     cfg_width_q;
    logic [OFM_BUF_AW-1:0] cfg_plane_q;

    // A cfg_load coinciding with a beat must apply to that beat, so bypass the registers.
    logic [4:0]            eff_shift;
    logic                  eff_act;
    logic [W_SIZE-1:0]     eff_width;
    logic [OFM_BUF_AW-1:0] eff_plane;

    always_comb begin
        eff_shift = cfg_load ? cfg_shift  : cfg_shift_q;
        eff_act   = cfg_load ? cfg_act_en : cfg_act_q;
        eff_width = cfg_load ? cfg_width  : cfg_width_q;
        eff_plane = cfg_load ? cfg_plane  : cfg_plane_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_shift_q <= '0;
            cfg_act_q   <= 1'b0;
            cfg_width_q <= '0;
            cfg_plane_q <= '0;
        end else if (cfg_load) begin
            cfg_shift_q <= cfg_shift;
            cfg_act_q   <= cfg_act_en;
            cfg_width_q <= cfg_width;
            cfg_plane_q <= cfg_plane;
        end
    end

    // Pipeline valid bits and status
    logic v1_q, v2_q, v3_q;
    logic tbl_err_q;

    always_comb busy = v1_q | v2_q | v3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            tbl_err_q <= 1'b0;
        end else begin
            v1_q <= pe_vld_i;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (tbl_we && busy) begin
                tbl_err_q <= 1'b1;
            end
        end
    end

    // Bias/scale table; not reset so contents survive rst
    logic [TBL_DW-1:0] tbl_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (tbl_we && !busy) begin
            tbl_mem[tbl_addr] <= {tbl_bias, tbl_scale};
        end
    end

    // Stage 1: table lookup and beat capture
    logic [W_CHANNEL-1:0]        rd_addr [LANES];
    logic signed [PSUM_DW-1:0]   psum_s1_q [LANES];
    logic signed [BIAS_DW-1:0]   bias_s1_q [LANES];
    logic [SCALES_DW-1:0]        scale_s1_q [LANES];
    logic [W_SIZE-1:0]           row_s1_q, col_s1_q, width_s1_q;
    logic [W_CHANNEL-1:0]        chn_s1_q;
    logic [OFM_BUF_AW-1:0]       plane_s1_q;
    logic [4:0]                  shift_s1_q;
    logic                        act_s1_q;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            rd_addr[k] = pe_chn_out_i + W_CHANNEL'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (pe_vld_i) begin
            for (int k = 0; k < LANES; k++) begin
                psum_s1_q[k]  <= pe_data_i[k*PSUM_DW +: PSUM_DW];
                bias_s1_q[k]  <= tbl_mem[rd_addr[k]][TBL_DW-1:SCALES_DW];
                scale_s1_q[k] <= tbl_mem[rd_addr[k]][SCALES_DW-1:0];
            end
            row_s1_q   <= pe_row_i;
            col_s1_q   <= pe_col_i;
            chn_s1_q   <= pe_chn_out_i;
            width_s1_q <= eff_width;
            plane_s1_q <= eff_plane;
            shift_s1_q <= eff_shift;
            act_s1_q   <= eff_act;
        end
    end

    // Stage 2: (psum + bias) * scale, and the buffer address
    logic signed [PSUM_DW:0]  sum_s2 [LANES];
    logic signed [TW-1:0]     prod_s2 [LANES];
    logic signed [TW-1:0]     t_s2_q [LANES];
    logic [OFM_BUF_AW-1:0]    grp_a, row_a, col_a, width_a, addr_s2_d, addr_s2_q;
    logic [4:0]               shift_s2_q;
    logic                     act_s2_q;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            sum_s2[k]  = $signed({psum_s1_q[k][PSUM_DW-1], psum_s1_q[k]})
                       + (PSUM_DW+1)'(bias_s1_q[k]);
            // Scale is unsigned: prepend a zero sign bit before the signed multiply.
            prod_s2[k] = TW'(sum_s2[k]) * TW'($signed({1'b0, scale_s1_q[k]}));
        end
        // Modular arithmetic: truncating each term first gives the same wrapped sum.
        grp_a     = OFM_BUF_AW'(chn_s1_q / W_CHANNEL'(LANES));
        row_a     = OFM_BUF_AW'(row_s1_q);
        col_a     = OFM_BUF_AW'(col_s1_q);
        width_a   = OFM_BUF_AW'(width_s1_q);
        addr_s2_d = grp_a * plane_s1_q + row_a * width_a + col_a;
    end

    always_ff @(posedge clk) begin
        if (v1_q) begin
            for (int k = 0; k < LANES; k++) begin
                t_s2_q[k] <= prod_s2[k];
            end
            addr_s2_q  <= addr_s2_d;
            shift_s2_q <= shift_s1_q;
            act_s2_q   <= act_s1_q;
        end
    end

    // Stage 3: round, leaky-ReLU, saturate
    logic [RW-1:0]           rnd_add;
    logic signed [RW-1:0]    rnd_s3 [LANES];
    logic signed [RW-1:0]    act_s3 [LANES];
    logic [LANES*W_OUT-1:0]  wdata_d;
    logic [16:0]             clip_sum;
    logic [16:0]             sat_sum;
    logic [15:0]             sat_d;

    always_comb begin
        // Half an LSB of the result: 1 << (shift-1), or 0 when shift is 0.
        rnd_add  = (RW'(1) << shift_s2_q) >> 1;
        wdata_d  = '0;
        clip_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            rnd_s3[k] = ($signed(RW'(t_s2_q[k])) + $signed(rnd_add)) >>> shift_s2_q;
            act_s3[k] = (act_s2_q && rnd_s3[k][RW-1]) ? (rnd_s3[k] >>> 3) : rnd_s3[k];
            if (act_s3[k] > MAXV) begin
                wdata_d[k*W_OUT +: W_OUT] = MAXV[W_OUT-1:0];
                clip_sum = clip_sum + 17'd1;
            end else if (act_s3[k] < MINV) begin
                wdata_d[k*W_OUT +: W_OUT] = MINV[W_OUT-1:0];
                clip_sum = clip_sum + 17'd1;
            end else begin
                wdata_d[k*W_OUT +: W_OUT] = act_s3[k][W_OUT-1:0];
            end
        end
        sat_sum = {1'b0, sat_cnt} + clip_sum;
        sat_d   = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    logic [OFM_BUF_AW-1:0]  ofm_addr_q;
    logic [LANES*W_OUT-1:0] ofm_wdata_q;
    logic [15:0]            sat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ofm_addr_q  <= '0;
            ofm_wdata_q <= '0;
            sat_cnt_q   <= '0;
        end else if (v2_q) begin
            ofm_addr_q  <= addr_s2_q;
            ofm_wdata_q <= wdata_d;
            sat_cnt_q   <= sat_d;
        end
    end

    always_comb begin
        ofm_we    = v3_q;
        ofm_addr  = ofm_addr_q;
        ofm_wdata = ofm_wdata_q;
        tbl_err   = tbl_err_q;
        sat_cnt   = sat_cnt_q;
    end

endmodule
